xalu_req_fifo: RTL and testbench
================================

Name: xalu_req_fifo

Overview:
- Parametrised successor to the fixed per-thread complex-ALU (MUL/DIV) input FIFO.
- Queues IU requests (tid, op1, op2, mode) ahead of the xalu functional units.
- Generates even parity per field on enqueue and checks it on dequeue.
- Drops replayed requests, precomputes op2zero for divide-by-zero, and reports occupancy, almost-full and overflow; depth, data width, tid width and mode width are all generic.

Parameters:
DATA_W, 32, operand width (op1/op2)
TID_W, 6, thread id width
MODE_W, 3, mode field width
DEPTH, 64, entries; power of two, >=2
AFULL_TH, 56, count at or above which afull asserts

Ports:
gclk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  enqueue request
in_replay  in  1  request is a replay; dropped when set
in_tid  in  TID_W  thread id
in_op1  in  DATA_W  operand 1
in_op2  in  DATA_W  operand 2
in_mode  in  MODE_W  xalu mode
inj_err  in  3  test-only parity inject {misc,op2,op1}; qualified by enqueue
full  out  1  count==DEPTH
afull  out  1  count>=AFULL_TH
count  out  $clog2(DEPTH)+1  occupancy
out_valid  out  1  head entry present
out_ready  in  1  consumer dequeues head when out_valid
out_tid  out  TID_W  head tid
out_op1  out  DATA_W  head op1
out_op2  out  DATA_W  head op2
out_mode  out  MODE_W  head mode
out_op2zero  out  1  head op2==0
perr  out  3  parity mismatch {misc,op2,op1} on the dequeue cycle
perr_sticky  out  1  OR of all perr since reset
ovf_sticky  out  1  enqueue attempted while full, since reset

Behaviour:
- Clock and reset: single clock gclk; all state updates on the rising edge; rst is synchronous and active-high.
- Reset values:
  - head, tail, count = 0; full = 0; afull = 0 (AFULL_TH>0); out_valid = 0; perr = 0.
  - perr_sticky = 0; ovf_sticky = 0.
  - Storage contents are don't-care. Reset mid-traffic discards all entries next cycle.
- Pointers: head/tail are $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - Empty: head==tail.
  - Full: low bits equal and MSBs differ.
  - Pointers wrap from DEPTH-1 to 0 with the wrap bit toggled.
- Enqueue: accepted when in_valid & ~in_replay & ~full. full is the registered state at the start of the cycle.
  - Writes entry[tail] = {tid, op1, op2, mode, p_op1^inj_err[0], p_op2^inj_err[1], p_misc^inj_err[2]}, then tail++.
  - Parity is even-style XOR: p_op1 = ^op1, p_op2 = ^op2, p_misc = ^{tid, mode}.
  - op2zero = (op2==0) is stored at enqueue.
- Replay: in_valid & in_replay is silently discarded. No state change; ovf_sticky is not set.
- Overflow: in_valid & ~in_replay & full drops the request and sets ovf_sticky. The queue is unchanged.
- Dequeue: first-word-fall-through.
  - out_* is driven combinationally from entry[head] (distributed RAM); out_valid = ~empty.
  - Dequeue occurs when out_valid & out_ready; head++.
  - out_ready while empty is ignored.
- Latency: a write into an empty queue in cycle t gives out_valid=1 in cycle t+1.
- Parity check: combinational on the dequeue cycle only.
  - perr[i] = stored parity XOR recomputed parity of the head field; perr is 0 when no dequeue.
  - Data is delivered regardless of perr.
  - perr_sticky is set the cycle after any perr bit is 1.
- Simultaneous enqueue and dequeue:
  - Not full: count unchanged, both pointers advance.
  - Full: enqueue rejected (overflow, ovf_sticky set), dequeue proceeds, count = DEPTH-1 next cycle.
  - Empty: enqueue proceeds, no dequeue (out_valid was 0).
- count, full and afull are registered and updated from the accepted enqueue/dequeue of the same cycle.
- No ordering is enforced per tid; strict FIFO across all threads.

Test Plan:
1. Reset, then enqueue tid=5, op1=0x0000_0007, op2=0x0000_0003, mode=2 at cycle 1 -> cycle 2: out_valid=1, out_tid=5, out_op1=7, out_op2=3, out_mode=2, out_op2zero=0, count=1; dequeue -> perr=0, count=0, out_valid=0.
2. Enqueue DEPTH=64 entries with op1=i, no dequeue -> afull rises when count reaches 56; full=1 at count=64. 65th enqueue -> ovf_sticky=1, count stays 64. Drain 64 -> op1 sequence 0..63 in order, tail/head wrap, empty at end.
3. At full, in_valid & out_ready in the same cycle -> head dequeued, new request dropped, ovf_sticky=1, count=63. At count=10 with both asserted -> count remains 10.
4. Enqueue with in_replay=1, op1=0xDEAD_BEEF -> count stays 0, out_valid=0, ovf_sticky=0.
5. Enqueue op1=0x1, op2=0x0, inj_err=3'b010 -> out_op2zero=1; on dequeue perr=3'b010, perr_sticky=1 next cycle and held until rst; a following clean entry dequeues with perr=0.
6. Assert rst with 20 entries queued -> next cycle count=0, out_valid=0, full=0, perr_sticky=0, ovf_sticky=0; a subsequent enqueue behaves as in scenario 1.

Source files
------------

// File: rtl/xalu_req_fifo.sv
// xalu_req_fifo: request queue in front of the complex-ALU (MUL/DIV) units.
// It stores IU requests {tid, op1, op2, mode}. Each field gets even parity
// on enqueue, and the parity is checked on dequeue. Replayed requests are
// dropped. op2zero is computed ahead of time for divide-by-zero. The queue
// reports occupancy, almost-full and a sticky overflow flag.
//
// Handshake: the input side has no back-pressure. A request is taken when
// in_valid & ~in_replay & ~full. If the same request arrives while full, it
// is dropped and ovf_sticky is set. The output side is first-word-fall-through:
// out_valid means out_* shows the head entry, and a transfer happens in any
// cycle where out_valid & out_ready are both high. out_ready while empty is
// ignored.
module xalu_req_fifo #(
    parameter int DATA_W   = 32,
    parameter int TID_W    = 6,
    parameter int MODE_W   = 3,
    parameter int DEPTH    = 64,
    parameter int AFULL_TH = 56
) (
    input  logic                     gclk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_replay,
    input  logic [TID_W-1:0]         in_tid,
    input  logic [DATA_W-1:0]        in_op1,
    input  logic [DATA_W-1:0]        in_op2,
    input  logic [MODE_W-1:0]        in_mode,
    input  logic [2:0]               inj_err,
    output logic                     full,
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TID_W-1:0]         out_tid,
    output logic [DATA_W-1:0]        out_op1,
    output logic [DATA_W-1:0]        out_op2,
    output logic [MODE_W-1:0]        out_mode,
    output logic                     out_op2zero,
    output logic [2:0]               perr,
    output logic                     perr_sticky,
    output logic                     ovf_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointers carry an extra wrap bit. Equal pointers mean empty. Equal low
    // bits with different wrap bits mean full.
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          perr_sticky_q, perr_sticky_d;
    logic          ovf_sticky_q, ovf_sticky_d;

    // Storage has no reset; the pointers alone decide which entries are valid.
    logic [TID_W-1:0]  mem_tid  [DEPTH];
    logic [DATA_W-1:0] mem_op1  [DEPTH];
    logic [DATA_W-1:0] mem_op2  [DEPTH];
    logic [MODE_W-1:0] mem_mode [DEPTH];
    logic              mem_zero [DEPTH];
    logic [2:0]        mem_par  [DEPTH];

    logic          empty;
    logic          enq;
    logic          deq;
    logic          ovf;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic [2:0]    wr_par;
    logic [2:0]    rd_par;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    assign empty    = (head_q == tail_q);

    assign enq = in_valid & ~in_replay & ~full_q;
    assign ovf = in_valid & ~in_replay &  full_q;
    assign deq = ~empty & out_ready;

    // Parity in {misc, op2, op1} order. inj_err flips the stored bits so the
    // check path can be tested.
    assign wr_par = {^{in_tid, in_mode}, ^in_op2, ^in_op1} ^ inj_err;

    // Compute pointer, occupancy and flag next-state from the accepted
    // enqueue and dequeue.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        perr_sticky_d = perr_sticky_q | (|perr);
        ovf_sticky_d  = ovf_sticky_q | ovf;
        if (enq) begin
            tail_d = tail_q + CW'(1);
        end
        if (deq) begin
            head_d = head_q + CW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (tail_d[AW-1:0] == head_d[AW-1:0]) && (tail_d[AW] != head_d[AW]);
        afull_d = (count_d >= CW'(AFULL_TH));
    end

    // Register the control state, with synchronous reset.
    always_ff @(posedge gclk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            afull_q       <= 1'b0;
            perr_sticky_q <= 1'b0;
            ovf_sticky_q  <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            full_q        <= full_d;
            afull_q       <= afull_d;
            perr_sticky_q <= perr_sticky_d;
            ovf_sticky_q  <= ovf_sticky_d;
        end
    end

    // Write the accepted request into the tail slot.
    always_ff @(posedge gclk) begin
        if (enq) begin
            mem_tid[tail_idx]  <= in_tid;
            mem_op1[tail_idx]  <= in_op1;
            mem_op2[tail_idx]  <= in_op2;
            mem_mode[tail_idx] <= in_mode;
            mem_zero[tail_idx] <= (in_op2 == '0);
            mem_par[tail_idx]  <= wr_par;
        end
    end

    // Read the head slot combinationally and check parity only on a dequeue.
    always_comb begin
        rd_par = {^{mem_tid[head_idx], mem_mode[head_idx]},
                  ^mem_op2[head_idx], ^mem_op1[head_idx]};
        perr   = deq ? (mem_par[head_idx] ^ rd_par) : 3'b000;
    end

    assign out_valid   = ~empty;
    assign out_tid     = mem_tid[head_idx];
    assign out_op1     = mem_op1[head_idx];
    assign out_op2     = mem_op2[head_idx];
    assign out_mode    = mem_mode[head_idx];
    assign out_op2zero = mem_zero[head_idx];

    assign count       = count_q;
    assign full        = full_q;
    assign afull       = afull_q;
    assign perr_sticky = perr_sticky_q;
    assign ovf_sticky  = ovf_sticky_q;

endmodule

// File: tb/tb_xalu_req_fifo.sv
// tb_xalu_req_fifo: scoreboard bench for xalu_req_fifo. Driver tasks push the
// expected head record whenever they issue a request that the queue must
// accept. A negedge monitor keeps an abstract occupancy/sticky model,
// compares every DUT output, and pops the queue on each dequeue.
module tb_xalu_req_fifo;

    localparam int DATA_W   = 32;
    localparam int TID_W    = 6;
    localparam int MODE_W   = 3;
    localparam int DEPTH    = 64;
    localparam int AFULL_TH = 56;
    localparam int CW       = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TID_W-1:0]  tid;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [MODE_W-1:0] mode;
        logic              zero;
        logic [2:0]        err;
    } exp_t;
    localparam int EW = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic              rst;
    logic              in_valid, in_replay, out_ready;
    logic [TID_W-1:0]  in_tid;
    logic [DATA_W-1:0] in_op1, in_op2;
    logic [MODE_W-1:0] in_mode;
    logic [2:0]        inj_err;
    logic              full, afull, out_valid, out_op2zero, perr_sticky, ovf_sticky;
    logic [CW-1:0]     count;
    logic [TID_W-1:0]  out_tid;
    logic [DATA_W-1:0] out_op1, out_op2;
    logic [MODE_W-1:0] out_mode;
    logic [2:0]        perr;

    xalu_req_fifo #(
        .DATA_W(DATA_W), .TID_W(TID_W), .MODE_W(MODE_W),
        .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
    ) dut (
        .gclk(gclk), .rst(rst),
        .in_valid(in_valid), .in_replay(in_replay),
        .in_tid(in_tid), .in_op1(in_op1), .in_op2(in_op2), .in_mode(in_mode),
        .inj_err(inj_err),
        .full(full), .afull(afull), .count(count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tid(out_tid), .out_op1(out_op1), .out_op2(out_op2),
        .out_mode(out_mode), .out_op2zero(out_op2zero),
        .perr(perr), .perr_sticky(perr_sticky), .ovf_sticky(ovf_sticky)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int  m_cnt   = 0;     // model occupancy, owned by the monitor
    bit  m_ovf   = 1'b0;
    bit  m_ps    = 1'b0;
    bit  started = 1'b0;
    int  n_vec   = 0;
    int  n_err   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge gclk) begin
        exp_t e;
        bit   acc, dq;
        if (started && !rst) begin
            chk("count",       64'(count),       64'(m_cnt));
            chk("full",        64'(full),        64'(m_cnt == DEPTH));
            chk("afull",       64'(afull),       64'(m_cnt >= AFULL_TH));
            chk("out_valid",   64'(out_valid),   64'(m_cnt != 0));
            chk("ovf_sticky",  64'(ovf_sticky),  64'(m_ovf));
            chk("perr_sticky", 64'(perr_sticky), 64'(m_ps));
            if (m_cnt != 0) begin
                e = exp_t'(exp_q[0]);
                chk("out_tid",     64'(out_tid),     64'(e.tid));
                chk("out_op1",     64'(out_op1),     64'(e.op1));
                chk("out_op2",     64'(out_op2),     64'(e.op2));
                chk("out_mode",    64'(out_mode),    64'(e.mode));
                chk("out_op2zero", 64'(out_op2zero), 64'(e.zero));
                chk("perr",        64'(perr),        out_ready ? 64'(e.err) : 64'd0);
            end else begin
                chk("perr_idle", 64'(perr), 64'd0);
            end
        end
        if (rst) begin
            started = 1'b1;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_ps    = 1'b0;
            exp_q.delete();
        end else if (started) begin
            acc = in_valid && !in_replay && (m_cnt != DEPTH);
            dq  = out_ready && (m_cnt != 0);
            if (in_valid && !in_replay && m_cnt == DEPTH) m_ovf = 1'b1;
            if (dq) begin
                e = exp_t'(exp_q.pop_front());
                if (e.err != 3'b000) m_ps = 1'b1;
            end
            m_cnt = m_cnt + int'(acc) - int'(dq);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit rp, input logic [TID_W-1:0] tid,
                         input logic [DATA_W-1:0] op1, input logic [DATA_W-1:0] op2,
                         input logic [MODE_W-1:0] mode, input logic [2:0] err,
                         input bit rdy);
        exp_t e;
        in_valid  = v;
        in_replay = rp;
        in_tid    = tid;
        in_op1    = op1;
        in_op2    = op2;
        in_mode   = mode;
        inj_err   = err;
        out_ready = rdy;
        if (v && !rp && m_cnt != DEPTH) begin
            e.tid  = tid;
            e.op1  = op1;
            e.op2  = op2;
            e.mode = mode;
            e.zero = (op2 == 0);
            e.err  = err;   // stored parity ^ err vs recomputed parity = err
            exp_q.push_back(EW'(e));
        end
        @(posedge gclk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'b0, '0, '0, '0, '0, 3'b000, rdy);
    endtask

    task automatic push(input logic [DATA_W-1:0] op1, input bit rdy);
        drive(1'b1, 1'b0, TID_W'($urandom), op1, $urandom, MODE_W'($urandom), 3'b000, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_replay = 1'b0; out_ready = 1'b0;
        in_tid = '0; in_op1 = '0; in_op2 = '0; in_mode = '0; inj_err = '0;
        repeat (2) @(posedge gclk);
        #1;
        rst = 1'b0;

        // Single entry: visible next cycle, then dequeued clean.
        drive(1'b1, 1'b0, 6'd5, 32'h7, 32'h3, 3'd2, 3'b000, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full with op1 = i, then one overflow attempt.
        for (int i = 0; i < DEPTH; i++) push(DATA_W'(i), 1'b0);
        push(32'h1234, 1'b0);
        // Enqueue and dequeue together while full: dequeue wins, count 63.
        push(32'h5678, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
        idle(1'b0);

        // At count 10, enqueue and dequeue together keep the count at 10.
        for (int i = 0; i < 10; i++) push(DATA_W'(100 + i), 1'b0);
        push(32'h200, 1'b1);
        push(32'h201, 1'b1);
        for (int i = 0; i < 10; i++) idle(1'b1);
        idle(1'b0);

        // A replay is discarded and does not set overflow.
        do_reset();
        drive(1'b1, 1'b1, 6'd1, 32'hDEAD_BEEF, 32'h1, 3'd0, 3'b000, 1'b0);
        idle(1'b0);

        // Injected op2 parity error, then a clean entry.
        drive(1'b1, 1'b0, 6'd3, 32'h1, 32'h0, 3'd4, 3'b010, 1'b0);
        drive(1'b1, 1'b0, 6'd4, 32'h2, 32'h9, 3'd1, 3'b000, 1'b0);
        idle(1'b1);
        idle(1'b1);
        repeat (3) idle(1'b0);

        // Reset with 20 entries queued, then repeat the single-entry case.
        for (int i = 0; i < 20; i++) push(DATA_W'(i), 1'b0);
        do_reset();
        drive(1'b1, 1'b0, 6'd5, 32'h7, 32'h3, 3'd2, 3'b000, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Random traffic with bursty producer and consumer phases.
        for (int c = 0; c < 3000; c++) begin
            int  pv, pr;
            bit  v, rp, rdy;
            logic [2:0] err;
            logic [DATA_W-1:0] op2;
            pv  = ((c / 200) % 2 == 0) ? 75 : 35;
            pr  = ((c / 200) % 2 == 0) ? 35 : 75;
            v   = ($urandom_range(0, 99) < pv);
            rp  = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < pr);
            err = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(1, 7)) : 3'b000;
            op2 = ($urandom_range(0, 99) < 15) ? '0 : DATA_W'($urandom);
            if (c == 1500) do_reset();
            drive(v, rp, TID_W'($urandom), DATA_W'($urandom), op2,
                  MODE_W'($urandom), err, rdy);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
